// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART encodings (baud select, parity type), rx FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] BAUD_SEL_2400  = 2'b00;
    localparam logic [1:0] BAUD_SEL_4800  = 2'b01;
    localparam logic [1:0] BAUD_SEL_9600  = 2'b10;
    localparam logic [1:0] BAUD_SEL_19200 = 2'b11;

    localparam int unsigned BAUD_2400  = 2400;
    localparam int unsigned BAUD_4800  = 4800;
    localparam int unsigned BAUD_9600  = 9600;
    localparam int unsigned BAUD_19200 = 19200;

    // 2'b11 is decoded as "no parity", same as the transmit path.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int unsigned OVERSAMPLE  = 16;
    localparam logic [3:0]  MID_SAMPLE  = 4'd7;
    localparam logic [3:0]  LAST_SAMPLE = 4'd15;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    function automatic logic parity_enabled(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_if
// Brief    : Configuration, serial input and parallel result of the UART rx.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic       rx_in;
    logic [7:0] dout;
    logic       done;
    logic       receiving;
    logic       parity_error;
    logic       frame_error;

    modport master (
        output baud_rate, parity_type, rx_in,
        input  dout, done, receiving, parity_error, frame_error
    );

    modport slave (
        input  baud_rate, parity_type, rx_in,
        output dout, done, receiving, parity_error, frame_error
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_tick_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_tick_gen
// Brief    : 16x oversampling tick generator with synchronous restart.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_tick_gen #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [1:0] baud_sel_i,
    input  wire logic       restart_i,
    output logic            tick_o
);
    import uart_pkg::*;

    function automatic int unsigned divisor(input int unsigned baud);
        int unsigned raw;
        raw = CLK_FREQ / (baud * OVERSAMPLE);
        return (raw == 0) ? 1 : raw;
    endfunction

    localparam int unsigned DIV_2400  = divisor(BAUD_2400);
    localparam int unsigned DIV_4800  = divisor(BAUD_4800);
    localparam int unsigned DIV_9600  = divisor(BAUD_9600);
    localparam int unsigned DIV_19200 = divisor(BAUD_19200);
    localparam int unsigned CNT_W     = $clog2(DIV_2400 + 1);

    logic [CNT_W-1:0] term_cnt;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       baud_prev_q;
    logic             restart;

    always_comb begin
        term_cnt = CNT_W'(DIV_2400 - 1);
        case (baud_sel_i)
            BAUD_SEL_4800:  term_cnt = CNT_W'(DIV_4800 - 1);
            BAUD_SEL_9600:  term_cnt = CNT_W'(DIV_9600 - 1);
            BAUD_SEL_19200: term_cnt = CNT_W'(DIV_19200 - 1);
            default:        term_cnt = CNT_W'(DIV_2400 - 1);
        endcase
    end

    // A rate change mid-count would otherwise leave the counter past its new terminal value.
    assign restart = restart_i || (baud_sel_i != baud_prev_q);
    assign tick_o  = !restart && (cnt_q == term_cnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            baud_prev_q <= BAUD_SEL_2400;
        end else begin
            baud_prev_q <= baud_sel_i;
            if (restart || cnt_q == term_cnt) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_rx_top.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_top
// Brief    : UART receiver: synchroniser, 16x oversampled frame FSM, parity/stop check.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_top #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    uart_rx_if.slave  bus
);
    import uart_pkg::*;

    logic       sync1_q, sync2_q, rx_prev_q;
    logic       rx_fall;
    logic       tick;
    logic [1:0] baud_eff;
    logic       parity_ones;

    rx_state_e  state_q, state_d;
    logic [3:0] sample_q, sample_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] par_q, par_d;
    logic [1:0] baud_q, baud_d;
    logic       pbad_q, pbad_d;
    logic [7:0] dout_q, dout_d;
    logic       done_q, done_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= bus.rx_in;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    assign rx_fall = rx_prev_q && !sync2_q;

    // Until the frame is committed the live baud select drives the tick generator.
    assign baud_eff = (state_q == RX_IDLE || state_q == RX_START) ? bus.baud_rate : baud_q;

    uart_rx_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .baud_sel_i (baud_eff),
        .restart_i  (state_q == RX_IDLE),
        .tick_o     (tick)
    );

    assign parity_ones = (^shift_q) ^ sync2_q;

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        baud_d   = baud_q;
        pbad_d   = pbad_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        perr_d   = perr_q;
        ferr_d   = ferr_q;

        case (state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    state_d  = RX_START;
                    sample_d = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (sample_q == MID_SAMPLE) begin
                        sample_d = '0;
                        if (sync2_q) begin
                            state_d = RX_IDLE;
                        end else begin
                            state_d = RX_DATA;
                            idx_d   = '0;
                            par_d   = bus.parity_type;
                            baud_d  = bus.baud_rate;
                        end
                    end else begin
                        sample_d = sample_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (sample_q == LAST_SAMPLE) begin
                        sample_d          = '0;
                        shift_d[idx_q]    = sync2_q;
                        if (idx_q == 3'd7) begin
                            state_d = parity_enabled(par_q) ? RX_PARITY : RX_STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        sample_d = sample_q + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (tick) begin
                    if (sample_q == LAST_SAMPLE) begin
                        sample_d = '0;
                        pbad_d   = (par_q == PAR_ODD) ? !parity_ones : parity_ones;
                        state_d  = RX_STOP;
                    end else begin
                        sample_d = sample_q + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                // Finish at mid stop bit so a following start edge is never missed.
                if (tick) begin
                    if (sample_q == LAST_SAMPLE) begin
                        sample_d = '0;
                        dout_d   = shift_q;
                        ferr_d   = !sync2_q;
                        perr_d   = parity_enabled(par_q) && pbad_q;
                        done_d   = 1'b1;
                        state_d  = RX_IDLE;
                    end else begin
                        sample_d = sample_q + 4'd1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RX_IDLE;
            sample_q <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= PAR_NONE;
            baud_q   <= BAUD_SEL_2400;
            pbad_q   <= 1'b0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            baud_q   <= baud_d;
            pbad_q   <= pbad_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.done         = done_q;
    assign bus.receiving    = (state_q != RX_IDLE);
    assign bus.parity_error = perr_q;
    assign bus.frame_error  = ferr_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_top.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_top
// Brief    : Directed frames against a frame-level expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_top;
    import uart_pkg::*;

    localparam int unsigned CLK_FREQ = 1_536_000;
    localparam int          BIT_CLKS = 160;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_if bus_if ();

    uart_rx_top #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    exp_t       exp_q[$];
    exp_t       m_front;
    int         checks   = 0;
    int         failures = 0;
    int         done_cnt = 0;
    logic [7:0] m_dout   = 8'h00;
    logic       m_perr   = 1'b0;
    logic       m_ferr   = 1'b0;
    logic       prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected outcome of one frame from what was put on the line.
    function automatic exp_t expect_frame(input logic [7:0] d, input logic [1:0] ptype,
                                          input logic pbit, input logic stop_bit);
        exp_t e;
        int   ones;
        ones   = $countones({d, pbit});
        e.data = d;
        e.ferr = (stop_bit == 1'b0);
        if (ptype == PAR_ODD)       e.perr = (ones % 2 == 0);
        else if (ptype == PAR_EVEN) e.perr = (ones % 2 == 1);
        else                        e.perr = 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            m_dout    = 8'h00;
            m_perr    = 1'b0;
            m_ferr    = 1'b0;
            prev_done = 1'b0;
            check("rst_dout", 32'(bus_if.dout), 32'(m_dout));
            check("rst_done", 32'(bus_if.done), 32'(prev_done));
            check("rst_receiving", 32'(bus_if.receiving), 32'(prev_done));
        end else begin
            if (bus_if.done) begin
                done_cnt++;
                check("done_width", 32'(prev_done), 32'd0);
                check("receiving_at_done", 32'(bus_if.receiving), 32'd0);
                check("pending_frame", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    m_front = exp_q.pop_front();
                    m_dout  = m_front.data;
                    m_perr  = m_front.perr;
                    m_ferr  = m_front.ferr;
                end
            end
            check("dout", 32'(bus_if.dout), 32'(m_dout));
            check("parity_error", 32'(bus_if.parity_error), 32'(m_perr));
            check("frame_error", 32'(bus_if.frame_error), 32'(m_ferr));
            prev_done = bus_if.done;
        end
    end

    task automatic drive_bit(input logic v, input int n);
        bus_if.rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_bit);
        logic [1:0] ptype;
        ptype = bus_if.parity_type;
        exp_q.push_back(expect_frame(d, ptype, pbit, stop_bit));
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
        if (ptype == PAR_ODD || ptype == PAR_EVEN) drive_bit(pbit, BIT_CLKS);
        drive_bit(stop_bit, BIT_CLKS);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b0;
        bus_if.rx_in       = 1'b1;
        bus_if.baud_rate   = BAUD_SEL_9600;
        bus_if.parity_type = PAR_NONE;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout_lit", 32'(bus_if.dout), 32'h00);
        check("reset_flags_lit", 32'({bus_if.done, bus_if.receiving,
                                      bus_if.parity_error, bus_if.frame_error}), 32'h0);
        reset = 1'b1;
        drive_bit(1'b1, 20);

        send_frame(8'hA5, 1'b0, 1'b1);
        drive_bit(1'b1, 20);
        check("a5_done_count", 32'(done_cnt), 32'd1);
        check("a5_dout", 32'(bus_if.dout), 32'hA5);
        check("a5_errors", 32'({bus_if.parity_error, bus_if.frame_error}), 32'd0);
        check("a5_receiving", 32'(bus_if.receiving), 32'd0);

        bus_if.parity_type = PAR_EVEN;
        send_frame(8'h3C, 1'b0, 1'b1);
        drive_bit(1'b1, 20);
        check("3c_even_ok_dout", 32'(bus_if.dout), 32'h3C);
        check("3c_even_ok_perr", 32'(bus_if.parity_error), 32'd0);

        send_frame(8'h3C, 1'b1, 1'b1);
        drive_bit(1'b1, 20);
        check("3c_even_bad_dout", 32'(bus_if.dout), 32'h3C);
        check("3c_even_bad_perr", 32'(bus_if.parity_error), 32'd1);
        check("3c_done_count", 32'(done_cnt), 32'd3);

        bus_if.parity_type = PAR_NONE;
        send_frame(8'h81, 1'b0, 1'b0);
        drive_bit(1'b1, 20);
        check("81_dout", 32'(bus_if.dout), 32'h81);
        check("81_ferr", 32'(bus_if.frame_error), 32'd1);
        check("81_perr", 32'(bus_if.parity_error), 32'd0);

        drive_bit(1'b0, 40);
        drive_bit(1'b1, 200);
        check("glitch_done_count", 32'(done_cnt), 32'd4);
        check("glitch_receiving", 32'(bus_if.receiving), 32'd0);
        check("glitch_dout", 32'(bus_if.dout), 32'h81);

        // Reset lands halfway through data bit 3 of 8'hFF.
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, BIT_CLKS);
        drive_bit(1'b1, 80);
        check("midreset_receiving_before", 32'(bus_if.receiving), 32'd1);
        reset = 1'b0;
        #1;
        check("midreset_dout", 32'(bus_if.dout), 32'h00);
        check("midreset_flags", 32'({bus_if.done, bus_if.receiving,
                                     bus_if.parity_error, bus_if.frame_error}), 32'h0);
        drive_bit(1'b1, 20);
        reset = 1'b1;
        drive_bit(1'b1, 300);
        check("midreset_done_count", 32'(done_cnt), 32'd4);

        send_frame(8'h55, 1'b0, 1'b1);
        drive_bit(1'b1, 20);
        check("55_dout", 32'(bus_if.dout), 32'h55);
        check("55_errors", 32'({bus_if.parity_error, bus_if.frame_error}), 32'd0);

        send_frame(8'h12, 1'b0, 1'b1);
        check("b2b_first_dout", 32'(bus_if.dout), 32'h12);
        send_frame(8'h34, 1'b0, 1'b1);
        drive_bit(1'b1, 20);
        check("b2b_second_dout", 32'(bus_if.dout), 32'h34);
        check("b2b_errors", 32'({bus_if.parity_error, bus_if.frame_error}), 32'd0);
        check("final_done_count", 32'(done_cnt), 32'd7);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
- Receive-side counterpart of the UART transmitter top-level.
- Deserialises an asynchronous 8-bit frame (start, 8 data LSB-first, optional parity, 1 stop) from the serial line into a parallel byte.
- Flags parity and framing errors.
- Contains its own 16x oversampling tick generator driven by the same baud_rate/parity_type encodings as the transmit path, so a TX/RX pair configured identically interoperates.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- OVERSAMPLE, 16, ticks per bit period; fixed at 16, mid-bit sample at tick 7.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- baud_rate  input  2  00=2400, 01=4800, 10=9600, 11=19200 baud
- parity_type  input  2  00=none, 01=odd, 10=even, 11=none
- rx_in  input  1  serial line; idles high; asynchronous to clk
- dout  output  8  last received byte
- done  output  1  one-clk pulse when a frame completes
- receiving  output  1  high while a frame is in progress (state != IDLE)
- parity_error  output  1  parity mismatch on last frame
- frame_error  output  1  stop bit sampled low on last frame

Behaviour:
- Reset (reset=0, async): state=IDLE; dout=8'h00; done=0; receiving=0; parity_error=0; frame_error=0; tick counter=0; synchroniser flops=1.
- rx_in passes through a 2-flop synchroniser (reset value 1) before any use. Edge/sample latency is 2 clk.
- Tick generator: divisor = CLK_FREQ/(baud*16), integer truncation. It emits a 1-clk tick every divisor clocks.
  - Counter restarts at 0 when baud_rate changes and while IDLE.
  - Ticks are aligned to the detected start edge.
- FSM states: IDLE, START, DATA, PARITY, STOP. A 4-bit sample counter counts ticks within a bit; a 3-bit index counts data bits.
  - IDLE: on synchronised rx falling edge (1 -> 0), go to START and clear the sample counter.
  - START: at tick 7, if rx=1 this is a false start: go to IDLE with no output change. Otherwise reset the sample counter and go to DATA.
  - DATA: every 16 ticks (mid-bit), shift rx into bit[index], LSB first. After index 7, go to PARITY if parity_type is 01/10, else go to STOP.
  - PARITY: at mid-bit, capture the received bit.
    - Odd: error if XOR(data, pbit) = 0.
    - Even: error if XOR(data, pbit) = 1.
  - STOP: at mid-bit, in that same clk:
    - load dout with the shifted byte;
    - set frame_error = ~rx;
    - set parity_error (forced 0 when no parity);
    - pulse done for 1 clk;
    - return to IDLE.
  - STOP does not wait for the full stop period; back-to-back frames are accepted from the half stop bit onward.
- dout, parity_error and frame_error update only on done and hold until the next done. A frame with an error still loads dout.
- parity_type and baud_rate are sampled at the START->DATA transition. Changes mid-frame take effect on the next frame.
- Break condition (rx held low): the frame completes with frame_error=1 and dout=8'h00. The FSM then waits in IDLE for rx to return high before a new falling edge can occur.
- Reset asserted mid-frame: immediate return to reset values, no done pulse.
- receiving rises 1 clk after edge detection and falls in the clk after done.

Decomposition:
- Package uart_pkg:
  - baud encodings and baud constants (2400/4800/9600/19200);
  - parity_type encodings (PAR_NONE, PAR_ODD, PAR_EVEN);
  - rx FSM state enum;
  - OVERSAMPLE and MID_SAMPLE=7.
- Shared with the transmit path where applicable.
- One natural sub-module: uart_rx_tick_gen (divisor select, tick counter, restart input).
- The FSM, synchroniser and parity check live in uart_rx_top.

Test Plan:
- Bench override: CLK_FREQ=1_536_000, baud_rate=10, giving divisor 10 and 160 clk/bit.
- Frame 8'hA5, parity none, good stop -> done pulse, dout=8'hA5, parity_error=0, frame_error=0, receiving low after done.
- Frame 8'h3C, parity_type=10 (even), parity bit 0 -> dout=8'h3C, parity_error=0.
- Repeat with parity bit 1 -> parity_error=1, dout still 8'h3C.
- Frame 8'h81, stop bit driven 0 -> done, frame_error=1, dout=8'h81.
- Glitch: rx low for 40 clk (<half bit), then high -> no done, receiving returns 0, dout unchanged.
- Mid-frame reset: assert reset during data bit 3 of 8'hFF -> all outputs 0 immediately, no done.
- Then a clean 8'h55 -> dout=8'h55.
- Back-to-back: 8'h12 then 8'h34 with no idle gap -> two done pulses, dout sequence 8'h12, 8'h34, no errors.
